// File: rtl/tlm_chan_mux_pkg.sv
// Shared types and constants for the channel multiplexer.
// Optional checksum trailer is selected with the TLM_MUX_CSUM_EN macro.
package tlm_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned HDR_SEG_BIT = 7;
  localparam int unsigned HDR_CH_W    = 7;

`ifdef TLM_MUX_CSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY} state_t;
`endif

  typedef enum logic {MODE_PKT, MODE_SEG} mode_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/tlm_chan_mux_if.sv
// Bundle of the per-channel input streams and the framed output stream.
// master = traffic source/sink side, slave = multiplexer side.
interface tlm_chan_mux_if #(parameter int unsigned NUM_CH = 4);
  import tlm_pkg::*;

  logic [NUM_CH-1:0]        in_valid;
  logic [BYTE_W*NUM_CH-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [BYTE_W-1:0]        out_data;
  logic                     out_last;
  logic                     out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/tlm_chan_mux_fifo.sv
// Per-channel {last,data} FIFO with a count of stored end-of-packet entries.
// Exposes the head and the entry behind it so the frame output can be
// preloaded one byte ahead.
module tlm_chan_fifo
  import tlm_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output entry_t                   head,
  output entry_t                   head_next,
  output logic [$clog2(DEPTH):0]   eop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_pop;
  logic            eop_in;
  logic            eop_out;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];
  assign do_pop    = pop && !empty;
  assign eop_in    = push && push_entry.last;
  assign eop_out   = do_pop && head.last;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Pointers, occupancy and end-of-packet count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      eop_cnt <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      case ({eop_in, eop_out})
        2'b10:   eop_cnt <= eop_cnt + (AW+1)'(1);
        2'b01:   eop_cnt <= eop_cnt - (AW+1)'(1);
        default: eop_cnt <= eop_cnt;
      endcase
    end
  end

endmodule

// File: rtl/tlm_chan_mux.sv
// Round-robin multiplexer of NUM_CH byte streams into one framed stream:
// header {seg, ch} followed by a packet or a full-FIFO segment.
// Define TLM_MUX_CSUM_EN to append an XOR checksum trailer to every frame.
module tlm_chan_mux
  import tlm_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  tlm_chan_mux_if.slave   bus
);

  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] SEG_LAST   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] SEG_PENULT = (AW+1)'(DEPTH - 2);

  entry_t            head      [NUM_CH];
  entry_t            head_next [NUM_CH];
  logic [AW:0]       eop_cnt   [NUM_CH];
  logic [NUM_CH-1:0] full, empty, push, pop, elig;

  state_t            state;
  mode_t             mode;
  logic [CW-1:0]     grant, last_grant;
  logic [AW:0]       seg_cnt;
  logic              frame_valid, frame_last;
  logic [BYTE_W-1:0] frame_data;
`ifdef TLM_MUX_CSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  logic              hs, found, frame_end, next_last;
  logic [CW-1:0]     pick, cand;
  mode_t             pick_mode;
  entry_t            g_head, g_next;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tlm_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[c]),
      .push_entry ({bus.in_last[c], bus.in_data[BYTE_W*c +: BYTE_W]}),
      .pop        (pop[c]),
      .full       (full[c]),
      .empty      (empty[c]),
      .head       (head[c]),
      .head_next  (head_next[c]),
      .eop_cnt    (eop_cnt[c])
    );
    assign push[c] = bus.in_valid[c] && !full[c];
    assign pop[c]  = (state == ST_PAY) && hs && (grant == CW'(c)) && !empty[c];
    assign elig[c] = (eop_cnt[c] != '0) || full[c];
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = frame_valid;
  assign bus.out_data  = frame_data;
  assign bus.out_last  = frame_last;

  assign hs        = frame_valid && bus.out_ready;
  assign g_head    = head[grant];
  assign g_next    = head_next[grant];
  assign frame_end = (mode == MODE_PKT) ? g_head.last : (seg_cnt == SEG_LAST);
  assign next_last = (mode == MODE_PKT) ? g_next.last : (seg_cnt == SEG_PENULT);

  // Round-robin search for the first eligible channel after last_grant.
  always_comb begin
    found     = 1'b0;
    pick      = last_grant;
    pick_mode = MODE_PKT;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = CW'((32'(last_grant) + i) % NUM_CH);
      if (!found && elig[cand]) begin
        found     = 1'b1;
        pick      = cand;
        pick_mode = (eop_cnt[cand] != '0) ? MODE_PKT : MODE_SEG;
      end
    end
  end

  // Frame FSM; output byte is preloaded one step ahead from the FIFO
  // head/next entries so out_* stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode        <= MODE_PKT;
      grant       <= '0;
      last_grant  <= CW'(NUM_CH - 1);
      seg_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_last  <= 1'b0;
      frame_data  <= '0;
`ifdef TLM_MUX_CSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state       <= ST_HDR;
            grant       <= pick;
            last_grant  <= pick;
            mode        <= pick_mode;
            seg_cnt     <= '0;
            frame_valid <= 1'b1;
            frame_last  <= 1'b0;
            frame_data  <= {pick_mode == MODE_SEG, HDR_CH_W'(pick)};
`ifdef TLM_MUX_CSUM_EN
            csum        <= '0;
`endif
          end
        end
        ST_HDR: begin
          if (hs) begin
            state      <= ST_PAY;
            frame_data <= g_head.data;
`ifdef TLM_MUX_CSUM_EN
            frame_last <= 1'b0;
            csum       <= csum ^ frame_data;
`else
            frame_last <= (mode == MODE_PKT) && g_head.last;
`endif
          end
        end
        ST_PAY: begin
          if (hs) begin
            seg_cnt <= seg_cnt + (AW+1)'(1);
`ifdef TLM_MUX_CSUM_EN
            csum    <= csum ^ frame_data;
`endif
            if (frame_end) begin
`ifdef TLM_MUX_CSUM_EN
              state      <= ST_CSUM;
              frame_data <= csum ^ frame_data;
              frame_last <= 1'b1;
`else
              state       <= ST_IDLE;
              frame_valid <= 1'b0;
              frame_last  <= 1'b0;
`endif
            end else begin
              frame_data <= g_next.data;
`ifdef TLM_MUX_CSUM_EN
              frame_last <= 1'b0;
`else
              frame_last <= next_last;
`endif
            end
          end
        end
`ifdef TLM_MUX_CSUM_EN
        ST_CSUM: begin
          if (hs) begin
            state       <= ST_IDLE;
            frame_valid <= 1'b0;
            frame_last  <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlm_chan_mux.sv
// Self-checking bench for tlm_chan_mux: table of packets plus hand-written
// sequences; expected frame bytes queue up as stimulus is driven and are
// compared as the DUT emits them.
module tb_tlm_chan_mux;
  import tlm_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlm_chan_mux_if #(.NUM_CH(NUM_CH)) bus ();

  tlm_chan_mux #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [7:0] pkt_q[$];

  bit   toggle_mode = 1'b0;
  logic ready_hold  = 1'b1;
  logic ready_cur   = 1'b1;

  typedef struct {
    int unsigned ch;
    int unsigned len;
    logic [7:0]  d [5];
    bit          tog;
  } vec_t;

  vec_t vecs [5];

  always @(posedge clk) begin
    #1;
    if (toggle_mode) ready_cur = ~ready_cur;
    else             ready_cur = ready_hold;
    bus.out_ready = ready_cur;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: stream order/content and hold-while-stalled.
  logic       stalled = 1'b0;
  logic [8:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'({bus.out_last, bus.out_data}), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", {bus.out_last, bus.out_data});
        end else begin
          chk("stream", 32'({bus.out_last, bus.out_data}), 32'(exp_q.pop_front()));
        end
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held    = {bus.out_last, bus.out_data};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Expected frame for the bytes currently in pkt_q.
  task automatic add_frame(input int unsigned ch, input bit seg);
    logic [7:0] hdr;
    logic [7:0] sum;
    hdr = {seg, 7'(ch)};
    sum = hdr;
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < pkt_q.size(); i++) begin
`ifdef TLM_MUX_CSUM_EN
      exp_q.push_back({1'b0, pkt_q[i]});
`else
      exp_q.push_back({i == pkt_q.size() - 1, pkt_q[i]});
`endif
      sum = sum ^ pkt_q[i];
    end
`ifdef TLM_MUX_CSUM_EN
    exp_q.push_back({1'b1, sum});
`endif
    pkt_q.delete();
  endtask

  task automatic push_byte(input int unsigned ch, input logic [7:0] d, input logic l);
    int   n;
    logic acc;
    bus.in_valid[ch]       = 1'b1;
    bus.in_data[8*ch +: 8] = d;
    bus.in_last[ch]        = l;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready[ch];
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    bus.in_valid[ch] = 1'b0;
    bus.in_last[ch]  = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 on ch %0d", ch);
    end
  endtask

  task automatic push_multi(input logic [NUM_CH-1:0] mask, input logic [7:0] base);
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bus.in_valid[c]       = mask[c];
      bus.in_data[8*c +: 8] = base + 8'(c);
      bus.in_last[c]        = mask[c];
    end
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    bus.in_last  = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int unsigned ch, input int unsigned len,
                         input logic [39:0] bytes, input bit tog);
    vecs[i].ch  = ch;
    vecs[i].len = len;
    vecs[i].tog = tog;
    for (int j = 0; j < 5; j++) vecs[i].d[j] = bytes[39-8*j -: 8];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    set_vec(0, 2, 3, 40'h1122330000, 1'b0);
    set_vec(1, 0, 1, 40'hA500000000, 1'b0);
    set_vec(2, 3, 5, 40'h0102030405, 1'b1);
    set_vec(3, 1, 2, 40'hC0C1000000, 1'b0);
    set_vec(4, 2, 5, 40'hF0F1F2F3F4, 1'b1);

    rst          = 1'b1;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_last  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'hF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Table of single packets, some under toggling backpressure.
    for (int i = 0; i < 5; i++) begin
      toggle_mode = vecs[i].tog;
      for (int j = 0; j < int'(vecs[i].len); j++) pkt_q.push_back(vecs[i].d[j]);
      add_frame(vecs[i].ch, 1'b0);
      for (int j = 0; j < int'(vecs[i].len); j++)
        push_byte(vecs[i].ch, vecs[i].d[j], j == int'(vecs[i].len) - 1);
      wait_drain();
      toggle_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end

    // Push-to-header latency and header contents.
    pkt_q.push_back(8'h5A);
    add_frame(2, 1'b0);
    push_byte(2, 8'h5A, 1'b1);
    @(negedge clk);
    chk("lat_grant_cycle_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_hdr_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_hdr_data",  32'(bus.out_data),  32'h02);
    wait_drain();

    // Round-robin: all four channels ready at once, twice.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        pkt_q.push_back(8'(8'hA0 + 8'(16 * r) + 8'(c)));
        add_frame(c, 1'b0);
      end
      push_multi(4'hF, 8'(8'hA0 + 8'(16 * r)));
      wait_drain();
    end

    // Round-robin from a mid-ring last grant: after ch1, ch3 beats ch0.
    pkt_q.push_back(8'h77);
    add_frame(1, 1'b0);
    push_byte(1, 8'h77, 1'b1);
    wait_drain();
    pkt_q.push_back(8'hD3);
    add_frame(3, 1'b0);
    pkt_q.push_back(8'hD0);
    add_frame(0, 1'b0);
    push_multi(4'b1001, 8'hD0);
    wait_drain();

    // Segment mode: full FIFO without any last byte.
    do_reset();
    for (int j = 0; j < int'(DEPTH); j++) pkt_q.push_back(8'(j));
    add_frame(1, 1'b1);
    for (int j = 0; j < int'(DEPTH); j++) begin
      if (j == int'(DEPTH) - 1) begin
        @(negedge clk);
        chk("seg_ready_before_full", 32'(bus.in_ready[1]), 32'd1);
        @(posedge clk);
        #1;
      end
      push_byte(1, 8'(j), 1'b0);
    end
    @(negedge clk);
    chk("seg_ready_full", 32'(bus.in_ready[1]), 32'd0);
    @(posedge clk);
    #1;
    wait_drain();

    // Granted channel queues a second packet during its own frame.
    ready_hold = 1'b0;
    pkt_q.push_back(8'hA1);
    pkt_q.push_back(8'hA2);
    pkt_q.push_back(8'hA3);
    add_frame(0, 1'b0);
    pkt_q.push_back(8'hB1);
    pkt_q.push_back(8'hB2);
    add_frame(0, 1'b0);
    push_byte(0, 8'hA1, 1'b0);
    push_byte(0, 8'hA2, 1'b0);
    push_byte(0, 8'hA3, 1'b1);
    push_byte(0, 8'hB1, 1'b0);
    push_byte(0, 8'hB2, 1'b1);
    ready_hold = 1'b1;
    wait_drain();

    // Reset while a frame is stalled on its header.
    ready_hold = 1'b0;
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h22, 1'b0);
    push_byte(2, 8'h33, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midframe_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'hF);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    ready_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_midrst_idle", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Fresh traffic after the aborted frame.
    pkt_q.push_back(8'h3C);
    add_frame(3, 1'b0);
    push_byte(3, 8'h3C, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
